// File: rtl/if_id_skid_pkg.sv
// rtl/if_id_skid_pkg.sv - shared pipeline defaults, NOP encoding and main-entry source select
package if_id_skid_pkg;

  localparam int DEF_LANES   = 2;
  localparam int DEF_PC_W    = 32;
  localparam int DEF_INSTR_W = 32;
  localparam int DEF_CNT_W   = 16;

  // Inactive lanes present an all-zero PC and instruction (NOP).
  localparam logic NOP_BIT = 1'b0;

  typedef enum logic [1:0] {
    MAIN_HOLD,
    MAIN_FROM_IN,
    MAIN_FROM_SKID,
    MAIN_CLEAR
  } main_sel_e;

endpackage

// File: rtl/if_id_skid_if.sv
// rtl/if_id_skid_if.sv - IF->ID bundle handshake bundle with driver (master) and stage (slave) views
interface if_id_skid_if
  import if_id_skid_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int CNT_W   = DEF_CNT_W
);

  logic                       flush;
  logic [LANES-1:0]           in_valid;
  logic [LANES*PC_W-1:0]      in_pc;
  logic [LANES*INSTR_W-1:0]   in_instr;
  logic                       in_ready;
  logic [LANES-1:0]           out_valid;
  logic [LANES*PC_W-1:0]      out_pc;
  logic [LANES*INSTR_W-1:0]   out_instr;
  logic                       out_ready;
  logic [CNT_W-1:0]           stall_cnt;

  modport master (
    output flush, in_valid, in_pc, in_instr, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, stall_cnt
  );

  modport slave (
    input  flush, in_valid, in_pc, in_instr, out_ready,
    output in_ready, out_valid, out_pc, out_instr, stall_cnt
  );

endinterface

// File: rtl/bundle_entry.sv
// rtl/bundle_entry.sv - one fetch-bundle register (mask + PCs + instructions) with load/clear
module bundle_entry
  import if_id_skid_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic                     clear,
  input  logic [LANES-1:0]         d_mask,
  input  logic [LANES*PC_W-1:0]    d_pc,
  input  logic [LANES*INSTR_W-1:0] d_instr,
  output logic [LANES-1:0]         q_mask,
  output logic [LANES*PC_W-1:0]    q_pc,
  output logic [LANES*INSTR_W-1:0] q_instr
);

  logic [LANES*PC_W-1:0]    pc_m;
  logic [LANES*INSTR_W-1:0] instr_m;

  // Squash payload of masked-off lanes at load so the outputs need no gating.
  always_comb begin
    pc_m    = {(LANES*PC_W){NOP_BIT}};
    instr_m = {(LANES*INSTR_W){NOP_BIT}};
    for (int i = 0; i < LANES; i++) begin
      if (d_mask[i]) begin
        pc_m[i*PC_W +: PC_W]          = d_pc[i*PC_W +: PC_W];
        instr_m[i*INSTR_W +: INSTR_W] = d_instr[i*INSTR_W +: INSTR_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_mask  <= '0;
      q_pc    <= '0;
      q_instr <= '0;
    end else if (clear) begin
      q_mask  <= '0;
      q_pc    <= '0;
      q_instr <= '0;
    end else if (load) begin
      q_mask  <= d_mask;
      q_pc    <= pc_m;
      q_instr <= instr_m;
    end
  end

endmodule

// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - IF/ID pipeline register with one skid entry, flush and stall counter
module if_id_skid
  import if_id_skid_pkg::*;
#(
  parameter int LANES   = DEF_LANES,
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  if_id_skid_if.slave  bus
);

  logic [LANES-1:0]         main_mask, skid_mask, main_d_mask;
  logic [LANES*PC_W-1:0]    main_pc, skid_pc, main_d_pc;
  logic [LANES*INSTR_W-1:0] main_instr, skid_instr, main_d_instr;
  logic                     main_load, main_clear, skid_load, skid_clear;
  logic                     main_full, skid_full, skid_full_next;
  logic                     accept, release_b, in_ready_q;
  logic [CNT_W-1:0]         stall_q;
  main_sel_e                main_sel;

  assign main_full = |main_mask;
  assign skid_full = |skid_mask;
  assign accept    = (|bus.in_valid) && in_ready_q && !bus.flush;
  assign release_b = main_full && bus.out_ready;

  // in_ready_q is only set when the skid is empty, so an accept never meets a full skid.
  always_comb begin
    main_sel       = MAIN_HOLD;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    skid_full_next = skid_full;
    if (bus.flush) begin
      main_sel       = MAIN_CLEAR;
      skid_clear     = 1'b1;
      skid_full_next = 1'b0;
    end else if (release_b && skid_full) begin
      main_sel       = MAIN_FROM_SKID;
      skid_clear     = 1'b1;
      skid_full_next = 1'b0;
    end else if (accept && (!main_full || release_b)) begin
      main_sel       = MAIN_FROM_IN;
    end else if (accept) begin
      skid_load      = 1'b1;
      skid_full_next = 1'b1;
    end else if (release_b) begin
      main_sel       = MAIN_CLEAR;
    end
  end

  always_comb begin
    main_load    = (main_sel == MAIN_FROM_IN) || (main_sel == MAIN_FROM_SKID);
    main_clear   = (main_sel == MAIN_CLEAR);
    main_d_mask  = bus.in_valid;
    main_d_pc    = bus.in_pc;
    main_d_instr = bus.in_instr;
    if (main_sel == MAIN_FROM_SKID) begin
      main_d_mask  = skid_mask;
      main_d_pc    = skid_pc;
      main_d_instr = skid_instr;
    end
  end

  bundle_entry #(.LANES(LANES), .PC_W(PC_W), .INSTR_W(INSTR_W)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (main_load),
    .clear   (main_clear),
    .d_mask  (main_d_mask),
    .d_pc    (main_d_pc),
    .d_instr (main_d_instr),
    .q_mask  (main_mask),
    .q_pc    (main_pc),
    .q_instr (main_instr)
  );

  bundle_entry #(.LANES(LANES), .PC_W(PC_W), .INSTR_W(INSTR_W)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (skid_load),
    .clear   (skid_clear),
    .d_mask  (bus.in_valid),
    .d_pc    (bus.in_pc),
    .d_instr (bus.in_instr),
    .q_mask  (skid_mask),
    .q_pc    (skid_pc),
    .q_instr (skid_instr)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= !skid_full_next;
    end
  end

  // Stall cycles are counted even during flush; only reset clears the count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_q <= '0;
    end else if (main_full && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = main_mask;
  assign bus.out_pc    = main_pc;
  assign bus.out_instr = main_instr;
  assign bus.stall_cnt = stall_q;

endmodule

// File: tb/tb_if_id_skid.sv
// tb/tb_if_id_skid.sv - directed vector bench for if_id_skid (16-bit and 4-bit stall counter builds)
module tb_if_id_skid;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  if_id_skid_if #(.LANES(2), .PC_W(32), .INSTR_W(32), .CNT_W(16)) bus ();
  if_id_skid_if #(.LANES(2), .PC_W(32), .INSTR_W(32), .CNT_W(4))  bus4 ();

  if_id_skid #(.LANES(2), .PC_W(32), .INSTR_W(32), .CNT_W(16)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  if_id_skid #(.LANES(2), .PC_W(32), .INSTR_W(32), .CNT_W(4)) u_dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4)
  );

  assign bus4.flush     = bus.flush;
  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_pc     = bus.in_pc;
  assign bus4.in_instr  = bus.in_instr;
  assign bus4.out_ready = bus.out_ready;

  typedef struct {
    string       name;
    logic        flush;
    logic [1:0]  vin;
    logic [63:0] pc;
    logic [63:0] instr;
    logic        ordy;
    logic [1:0]  e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_instr;
    logic        e_rdy;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic f, input logic [1:0] v, input logic [63:0] p,
                       input logic [63:0] i, input logic r);
    bus.flush     = f;
    bus.in_valid  = v;
    bus.in_pc     = p;
    bus.in_instr  = i;
    bus.out_ready = r;
  endtask

  task automatic add(input string n, input logic f, input logic [1:0] v, input logic [63:0] p,
                     input logic [63:0] i, input logic r, input logic [1:0] ev,
                     input logic [63:0] ep, input logic [63:0] ei, input logic er,
                     input logic [15:0] ec);
    vec_t x;
    x.name = n; x.flush = f; x.vin = v; x.pc = p; x.instr = i; x.ordy = r;
    x.e_valid = ev; x.e_pc = ep; x.e_instr = ei; x.e_rdy = er; x.e_cnt = ec;
    vecs.push_back(x);
  endtask

  initial begin
    //   name          fl  vin    pc{l1,l0}                instr{l1,l0}               ordy  ev     exp pc                   exp instr                  rdy cnt
    add("basic",       0, 2'b11, {32'h4,   32'h0},   {32'h13,   32'h93},       1, 2'b11, {32'h4,   32'h0},   {32'h13,   32'h93},       1, 0);
    add("lane1_nop",   0, 2'b01, {32'h10,  32'h8},   {32'hdead, 32'h20080001}, 1, 2'b01, {32'h0,   32'h8},   {32'h0,    32'h20080001}, 1, 0);
    add("drain",       0, 2'b00, {32'h0,   32'h0},   {32'h0,    32'h0},        1, 2'b00, 64'h0,              64'h0,                     1, 0);
    add("a_held",      0, 2'b11, {32'h24,  32'h20},  {32'ha1,   32'ha0},       0, 2'b11, {32'h24,  32'h20},  {32'ha1,   32'ha0},       1, 0);
    add("b_skid",      0, 2'b11, {32'h2c,  32'h28},  {32'hb1,   32'hb0},       0, 2'b11, {32'h24,  32'h20},  {32'ha1,   32'ha0},       0, 1);
    add("c_blocked",   0, 2'b11, {32'h34,  32'h30},  {32'hc1,   32'hc0},       0, 2'b11, {32'h24,  32'h20},  {32'ha1,   32'ha0},       0, 2);
    add("release_a",   0, 2'b00, {32'h0,   32'h0},   {32'h0,    32'h0},        1, 2'b11, {32'h2c,  32'h28},  {32'hb1,   32'hb0},       1, 2);
    add("release_b",   0, 2'b00, {32'h0,   32'h0},   {32'h0,    32'h0},        1, 2'b00, 64'h0,              64'h0,                     1, 2);
    add("d_held",      0, 2'b11, {32'h3c,  32'h38},  {32'hd1,   32'hd0},       0, 2'b11, {32'h3c,  32'h38},  {32'hd1,   32'hd0},       1, 2);
    add("e_skid",      0, 2'b11, {32'h84,  32'h80},  {32'he1,   32'he0},       0, 2'b11, {32'h3c,  32'h38},  {32'hd1,   32'hd0},       0, 3);
    add("flush_full",  1, 2'b11, {32'h94,  32'h90},  {32'hf1,   32'hf0},       0, 2'b00, 64'h0,              64'h0,                     1, 4);
    add("after_flush", 0, 2'b00, {32'h0,   32'h0},   {32'h0,    32'h0},        1, 2'b00, 64'h0,              64'h0,                     1, 4);
    add("lane0_only",  0, 2'b01, {32'h44,  32'h40},  {32'h144,  32'h140},      1, 2'b01, {32'h0,   32'h40},  {32'h0,    32'h140},      1, 4);
    add("pass_thru",   0, 2'b10, {32'h4c,  32'h48},  {32'h14c,  32'h148},      1, 2'b10, {32'h4c,  32'h0},   {32'h14c,  32'h0},        1, 4);
    add("flush_held",  1, 2'b11, {32'h54,  32'h50},  {32'h154,  32'h150},      0, 2'b00, 64'h0,              64'h0,                     1, 5);

    drive(0, 2'b00, 64'h0, 64'h0, 0);
    reset_n = 1'b0;
    #12;
    chk("rst_valid", {62'h0, bus.out_valid}, 64'h0);
    chk("rst_pc",    bus.out_pc, 64'h0);
    chk("rst_instr", bus.out_instr, 64'h0);
    chk("rst_ready", {63'h0, bus.in_ready}, 64'h1);
    chk("rst_cnt",   {48'h0, bus.stall_cnt}, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      drive(vecs[k].flush, vecs[k].vin, vecs[k].pc, vecs[k].instr, vecs[k].ordy);
      @(negedge clk);
      chk({vecs[k].name, "_valid"}, {62'h0, bus.out_valid}, {62'h0, vecs[k].e_valid});
      chk({vecs[k].name, "_pc"},    bus.out_pc, vecs[k].e_pc);
      chk({vecs[k].name, "_instr"}, bus.out_instr, vecs[k].e_instr);
      chk({vecs[k].name, "_ready"}, {63'h0, bus.in_ready}, {63'h0, vecs[k].e_rdy});
      chk({vecs[k].name, "_cnt"},   {48'h0, bus.stall_cnt}, {48'h0, vecs[k].e_cnt});
    end

    // Saturation: fresh reset, then hold one bundle for 20 stalled cycles.
    reset_n = 1'b0;
    drive(0, 2'b00, 64'h0, 64'h0, 0);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 2'b11, {32'h74, 32'h70}, {32'h174, 32'h170}, 0);
    @(negedge clk);
    drive(0, 2'b00, 64'h0, 64'h0, 0);
    repeat (20) @(negedge clk);
    chk("sat_cnt16",  {48'h0, bus.stall_cnt}, 64'd20);
    chk("sat_cnt4",   {60'h0, bus4.stall_cnt}, 64'd15);
    chk("sat_stable", bus.out_pc, {32'h74, 32'h70});
    chk("sat_valid",  {62'h0, bus.out_valid}, 64'h3);

    // Fill the skid, then pulse reset between edges.
    drive(0, 2'b11, {32'h5c, 32'h58}, {32'h15c, 32'h158}, 0);
    @(negedge clk);
    chk("full_ready", {63'h0, bus.in_ready}, 64'h0);
    drive(0, 2'b00, 64'h0, 64'h0, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_valid", {62'h0, bus.out_valid}, 64'h0);
    chk("arst_pc",    bus.out_pc, 64'h0);
    chk("arst_ready", {63'h0, bus.in_ready}, 64'h1);
    chk("arst_cnt4",  {60'h0, bus4.stall_cnt}, 64'h0);
    #1 reset_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("no_stale", {62'h0, bus.out_valid}, 64'h0);
    end
    drive(0, 2'b01, {32'h64, 32'h60}, {32'h164, 32'h160}, 1);
    @(negedge clk);
    chk("post_rst_pc", bus.out_pc, {32'h0, 32'h60});
    drive(0, 2'b00, 64'h0, 64'h0, 1);
    @(negedge clk);
    chk("post_rst_drain", {62'h0, bus.out_valid}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
